prog_load_ctrl: RTL and testbench

- Boot and run controller for the 8-bit accumulator core.
- Takes a framed byte stream (length, opcodes, checksum) over a valid/ready handshake and writes the opcodes sequentially into the instruction RAM write port (write/writeop/writeaddr).
- Holds the core in reset while loading; on a good checksum, releases it to run or halt.
- Provides halt, single-step and resume control, plus a run-cycle counter and error status.

---
 rtl/prog_load_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_prog_load_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_ctrl.sv
// Boot/run controller: loads a framed opcode stream (length, opcodes, checksum) into
// instruction RAM, then releases the accumulator core to run, halt or single-step.
module prog_load_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              step_mode,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              resume_req,
  output logic              op_write,
  output logic [ADDR_W-1:0] op_addr,
  output logic [DATA_W-1:0] op_data,
  output logic              cpu_rst,
  output logic              cpu_ce,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [2:0]        state,
  output logic [1:0]        err_code
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [DATA_W-1:0]   op_data_q, op_data_d;
  logic                in_ready_q, in_ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                cpu_ce_q, cpu_ce_d;

  logic                xfer;
  logic                loading;
  logic                step_go;
  logic [TMR_W-1:0]    tmr_inc;

  assign xfer    = in_valid && in_ready_q;
  assign loading = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign tmr_inc = tmr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    tmr_d      = tmr_q;
    err_d      = err_q;
    run_d      = run_q;
    op_write_d = 1'b0;
    op_addr_d  = op_addr_q;
    op_data_d  = op_data_q;
    step_go    = 1'b0;

    // load_start outranks everything, including a byte offered on the same cycle
    if (load_start) begin
      state_d = S_LEN;
      err_d   = 2'd0;
      sum_d   = '0;
      cnt_d   = '0;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        S_LEN: begin
          if (xfer) begin
            len_d = in_data[ADDR_W-1:0];
            cnt_d = '0;
            if (in_data[ADDR_W-1:0] == '0) begin
              state_d = S_ERR;
              err_d   = 2'd1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            op_write_d = 1'b1;
            op_addr_d  = cnt_q;
            op_data_d  = in_data;
            sum_d      = sum_q + in_data;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == sum_q) begin
              state_d = step_mode ? S_HALT : S_RUN;
            end else begin
              state_d = S_ERR;
              err_d   = 2'd2;
            end
          end
        end
        S_RUN: begin
          if (halt_req) state_d = S_HALT;
        end
        S_HALT: begin
          // cpu_ce_q high here means a step is already in flight
          if (resume_req)                 state_d = S_RUN;
          else if (step_req && !cpu_ce_q) step_go = 1'b1;
        end
        default: ;
      endcase

      if (loading) begin
        if (xfer) begin
          tmr_d = '0;
        end else if (tmr_inc == TMR_W'(TIMEOUT)) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end else begin
          tmr_d = tmr_inc;
        end
      end
    end

    if (load_start)                    run_d = '0;
    else if (cpu_ce_q && run_q != '1)  run_d = run_q + 1'b1;

    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    cpu_rst_d  = (state_d == S_RUN) || (state_d == S_HALT);
    cpu_ce_d   = (state_d == S_RUN) || step_go;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      tmr_q      <= '0;
      err_q      <= 2'd0;
      run_q      <= '0;
      op_write_q <= 1'b0;
      op_addr_q  <= '0;
      op_data_q  <= '0;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b0;
      cpu_ce_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      run_q      <= run_d;
      op_write_q <= op_write_d;
      op_addr_q  <= op_addr_d;
      op_data_q  <= op_data_d;
      in_ready_q <= in_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      cpu_ce_q   <= cpu_ce_d;
    end
  end

  assign state      = state_q;
  assign err_code   = err_q;
  assign run_cycles = run_q;
  assign op_write   = op_write_q;
  assign op_addr    = op_addr_q;
  assign op_data    = op_data_q;
  assign in_ready   = in_ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign cpu_ce     = cpu_ce_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: random frames checked against a frame-level model
// (expected RAM writes, checksum, resulting mode and cycle count).
module tb_prog_load_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, load_start, in_valid, in_ready, step_mode;
  logic        halt_req, step_req, resume_req;
  logic [7:0]  in_data, op_addr, op_data;
  logic        op_write, cpu_rst, cpu_ce;
  logic [15:0] run_cycles;
  logic [2:0]  state;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  fdat[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && op_write) wr_q.push_back({op_addr, op_data});

  prog_load_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .step_mode(step_mode),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
    .op_write(op_write), .op_addr(op_addr), .op_data(op_data),
    .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .run_cycles(run_cycles),
    .state(state), .err_code(err_code)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gen_frame(input int len);
    fdat.delete();
    repeat (len) fdat.push_back(8'($urandom));
  endtask

  task automatic check_len;
    chk("len_state", state, 1);
    chk("len_rdy", in_ready, 1);
    chk("len_cpurst", cpu_rst, 0);
    chk("len_ce", cpu_ce, 0);
    chk("len_run", run_cycles, 0);
    chk("len_err", err_code, 0);
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    wr_q.delete();
    check_len;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    if (n == 20) chk("in_ready_wait", 0, 1);
    tick;
    in_valid = 1'b0;
  endtask

  // Sends length, payload and checksum (corrupted by cs_xor when nonzero) and checks the outcome.
  task automatic frame_body(input logic [7:0] cs_xor, input bit smode, input int maxgap);
    logic [7:0] s;
    s = 8'h00;
    foreach (fdat[i]) s = s + fdat[i];
    step_mode = smode;
    send_byte(8'(fdat.size()), $urandom_range(0, maxgap));
    foreach (fdat[i]) send_byte(fdat[i], $urandom_range(0, maxgap));
    send_byte(s ^ cs_xor, $urandom_range(0, maxgap));
    chk("wr_cnt", wr_q.size(), fdat.size());
    for (int i = 0; i < fdat.size() && i < wr_q.size(); i++)
      chk("wr_addr_data", wr_q[i], {i[7:0], fdat[i]});
    if (cs_xor != 8'h00) begin
      chk("bad_state", state, 6);
      chk("bad_err", err_code, 2);
      chk("bad_cpurst", cpu_rst, 0);
      chk("bad_ce", cpu_ce, 0);
      chk("bad_rdy", in_ready, 0);
    end else begin
      chk("ok_state", state, smode ? 5 : 4);
      chk("ok_err", err_code, 0);
      chk("ok_cpurst", cpu_rst, 1);
      chk("ok_ce", cpu_ce, smode ? 0 : 1);
      chk("ok_run", run_cycles, 0);
    end
  endtask

  task automatic do_steps(input int k, input int base);
    for (int j = 0; j < k; j++) begin
      repeat ($urandom_range(0, 2)) tick;
      chk("step_idle_ce", cpu_ce, 0);
      step_req = 1'b1;
      tick;
      step_req = 1'($urandom_range(0, 1));
      chk("step_ce", cpu_ce, 1);
      chk("step_state", state, 5);
      tick;
      step_req = 1'b0;
      chk("step_end_ce", cpu_ce, 0);
    end
    chk("step_run", run_cycles, base + k);
  endtask

  task automatic resume_and_run(input int base, input int m);
    resume_req = 1'b1;
    tick;
    resume_req = 1'b0;
    chk("resume_state", state, 4);
    chk("resume_ce", cpu_ce, 1);
    chk("resume_run", run_cycles, base);
    repeat (m) tick;
    chk("resume_run_m", run_cycles, base + m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k, p, sc;
    rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step_mode = 1'b0; halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0;
    repeat (2) tick;
    chk("rst_state", state, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_cpurst", cpu_rst, 0);
    chk("rst_ce", cpu_ce, 0);
    chk("rst_opw", op_write, 0);
    chk("rst_addr", op_addr, 0);
    chk("rst_data", op_data, 0);
    chk("rst_run", run_cycles, 0);
    chk("rst_err", err_code, 0);
    rst = 1'b1;
    tick;
    chk("idle_hold", state, 0);

    fdat = '{8'h1A, 8'h22, 8'hF5};
    start_load; frame_body(8'h00, 1'b0, 0);
    repeat (5) tick;
    chk("run_count5", run_cycles, 5);

    start_load; frame_body(8'h01, 1'b0, 0);
    repeat (3) tick;
    chk("err_hold", state, 6);
    chk("err_hold_rst", cpu_rst, 0);
    start_load; frame_body(8'h00, 1'b0, 1);

    start_load;
    send_byte(8'h00, 0);
    chk("zlen_state", state, 6);
    chk("zlen_err", err_code, 1);
    tick;
    chk("zlen_nowr", wr_q.size(), 0);

    start_load;
    send_byte(8'h03, 0);
    send_byte(8'h55, 0);
    repeat (TO - 1) tick;
    chk("to_before", state, 2);
    tick;
    chk("to_state", state, 6);
    chk("to_err", err_code, 3);
    chk("to_rdy", in_ready, 0);

    gen_frame(4);
    start_load; frame_body(8'h00, 1'b1, 2);
    do_steps(3, 0);
    resume_and_run(3, 4);

    halt_req = 1'b1; load_start = 1'b1;
    tick;
    halt_req = 1'b0; load_start = 1'b0;
    wr_q.delete();
    check_len;

    for (int it = 0; it < 16; it++) begin
      gen_frame($urandom_range(1, 10));
      sc = $urandom_range(0, 3);
      case (sc)
        0: begin
          start_load; frame_body(8'h00, 1'b0, 3);
          n = $urandom_range(0, 8);
          repeat (n) tick;
          chk("rnd_run", run_cycles, n);
          step_req = 1'b1; resume_req = 1'($urandom_range(0, 1));
          tick;
          step_req = 1'b0; resume_req = 1'b0;
          chk("rnd_run_ign", state, 4);
          halt_req = 1'b1;
          tick;
          halt_req = 1'b0;
          chk("rnd_halt_state", state, 5);
          chk("rnd_halt_ce", cpu_ce, 0);
          chk("rnd_halt_run", run_cycles, n + 2);
          tick;
          chk("rnd_halt_hold", run_cycles, n + 2);
        end
        1: begin
          start_load; frame_body(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 3);
        end
        2: begin
          start_load; frame_body(8'h00, 1'b1, 3);
          k = $urandom_range(1, 4);
          do_steps(k, 0);
          resume_and_run(k, $urandom_range(0, 5));
        end
        default: begin
          start_load;
          p = $urandom_range(0, fdat.size() - 1);
          send_byte(8'(fdat.size()), 0);
          for (int i = 0; i < p; i++) send_byte(8'($urandom), $urandom_range(0, 2));
          in_valid = 1'b1; in_data = 8'($urandom); load_start = 1'b1;
          tick;
          in_valid = 1'b0; load_start = 1'b0;
          wr_q.delete();
          check_len;
          frame_body(8'h00, 1'b0, 2);
        end
      endcase
    end

    gen_frame(5);
    start_load;
    send_byte(8'd5, 0);
    send_byte(fdat[0], 0);
    send_byte(fdat[1], 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_opw", op_write, 0);
    chk("arst_addr", op_addr, 0);
    chk("arst_data", op_data, 0);
    chk("arst_cpurst", cpu_rst, 0);
    chk("arst_ce", cpu_ce, 0);
    chk("arst_run", run_cycles, 0);
    chk("arst_err", err_code, 0);
    rst = 1'b1;
    tick;
    chk("arst_idle", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
